// File: rtl/data_mux_rr_pkg.sv
// Shared constants and helpers for the data_mux_rr block and its arbiter.
package data_mux_rr_pkg;

   // Channel choice: explicit select port or round-robin among valid channels.
   localparam int MODE_SEL = 0;
   localparam int MODE_RR  = 1;

   // Ceiling log2. Callers clamp the result to at least one bit.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/data_mux_rr_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps
// around, and the first requesting channel found wins.
module rr_arbiter
   import data_mux_rr_pkg::*;
#(
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic                gnt_valid,
   output logic [SEL_W-1:0]    gnt_idx
);

   // Scan the search distances from farthest to nearest so that the nearest
   // requester overwrites the others. The channel at distance i from ptr is
   // ptr+i, folded back below CHANNELS, which keeps indices >= CHANNELS out.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (req[k] && ((int'(ptr) + i == k) || (int'(ptr) + i == k + CHANNELS))) begin
               gnt_valid = 1'b1;
               gnt_idx   = SEL_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/data_mux_rr.sv
// N:1 data multiplexer with valid/ready handshakes and one output register.
// Channel choice comes from sel (MODE_SEL) or from a round-robin arbiter (MODE_RR).
module data_mux_rr
   import data_mux_rr_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int CHANNELS = 4,
   parameter  int MODE     = 0,
   localparam int SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic             loadEn;
   logic             grantValid;
   logic [SEL_W-1:0] grantIdx;
   logic [WIDTH-1:0] selData;

   logic [WIDTH-1:0] outData_q,  outData_d;
   logic [SEL_W-1:0] outChan_q,  outChan_d;
   logic             outValid_q, outValid_d;
   logic [SEL_W-1:0] ptr_q,      ptr_d;

   // The register can take new data when it is empty or is being drained now.
   assign loadEn = !outValid_q || out_ready;

   if (MODE == MODE_RR) begin : g_rr
      logic unusedSel;
      assign unusedSel = ^sel;

      rr_arbiter #(
         .CHANNELS (CHANNELS)
      ) u_arb (
         .req       (in_valid),
         .ptr       (ptr_q),
         .gnt_valid (grantValid),
         .gnt_idx   (grantIdx)
      );
   end else begin : g_sel
      // Explicit select: grant only a valid channel that exists; a sel value
      // at or above CHANNELS matches no k and so never grants.
      always_comb begin
         grantValid = 1'b0;
         grantIdx   = '0;
         for (int k = 0; k < CHANNELS; k++) begin
            if ((int'(sel) == k) && in_valid[k]) begin
               grantValid = 1'b1;
               grantIdx   = SEL_W'(k);
            end
         end
      end
   end

   // Pick the granted channel's data and raise ready on that channel only.
   always_comb begin
      selData  = '0;
      in_ready = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grantIdx == SEL_W'(k)) begin
            selData     = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = loadEn && grantValid;
         end
      end
   end

   // Next-state of the output stage. A transfer loads and advances the round-robin
   // pointer, a drain with no transfer clears valid, and a stall holds everything.
   always_comb begin
      outData_d  = outData_q;
      outChan_d  = outChan_q;
      outValid_d = outValid_q;
      ptr_d      = ptr_q;
      if (loadEn && grantValid) begin
         outData_d  = selData;
         outChan_d  = grantIdx;
         outValid_d = 1'b1;
         if (MODE == MODE_RR) begin
            ptr_d = (int'(grantIdx) == CHANNELS - 1) ? '0 : grantIdx + SEL_W'(1);
         end
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Output register and arbitration pointer, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outData_q  <= '0;
         outChan_q  <= '0;
         outValid_q <= 1'b0;
         ptr_q      <= '0;
      end else begin
         outData_q  <= outData_d;
         outChan_q  <= outChan_d;
         outValid_q <= outValid_d;
         ptr_q      <= ptr_d;
      end
   end

   assign out_data  = outData_q;
   assign out_chan  = outChan_q;
   assign out_valid = outValid_q;

endmodule
